// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the packet-framed FIFO read path.
package fifo_rd_pkg;

  localparam int unsigned LEN_LSB  = 0;
  localparam int unsigned BUF_CNT_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } rd_state_e;

  typedef struct packed {
    logic sop;
    logic eop;
  } frame_flags_t;

  // True when one more read may be issued without overrunning the 2-entry buffer.
  function automatic logic has_room(input logic [BUF_CNT_W-1:0] cnt,
                                    input logic pending,
                                    input logic pop);
    logic [2:0] used;
    used = 3'(cnt) + 3'(pending);
    return (used - 3'(pop)) < 3'd2;
  endfunction

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry {data, sop, eop} buffer; head entry is always presented on the outputs.
module fifo_skid2
  import fifo_rd_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  logic [W-1:0]         wr_data,
  input  logic                 wr_sop,
  input  logic                 wr_eop,
  input  logic                 pop,
  output logic                 head_valid,
  output logic [W-1:0]         head_data,
  output logic                 head_sop,
  output logic                 head_eop,
  output logic [BUF_CNT_W-1:0] count,
  output logic [BUF_CNT_W-1:0] count_next
);

  logic [W-1:0]         head_data_q, head_data_d;
  logic [W-1:0]         tail_data_q, tail_data_d;
  frame_flags_t         head_flg_q, head_flg_d;
  frame_flags_t         tail_flg_q, tail_flg_d;
  frame_flags_t         wr_flg;
  logic [BUF_CNT_W-1:0] cnt_q, cnt_d;
  logic                 valid_q, valid_d;

  // Shift-style buffer: head is the egress word, tail refills head on pop.
  always_comb begin
    head_data_d = head_data_q;
    tail_data_d = tail_data_q;
    head_flg_d  = head_flg_q;
    tail_flg_d  = tail_flg_q;
    cnt_d       = cnt_q;
    wr_flg      = '{sop: wr_sop, eop: wr_eop};

    case (cnt_q)
      2'd0: begin
        if (wr) begin
          head_data_d = wr_data;
          head_flg_d  = wr_flg;
          cnt_d       = 2'd1;
        end
      end
      2'd1: begin
        if (wr && pop) begin
          head_data_d = wr_data;
          head_flg_d  = wr_flg;
        end else if (pop) begin
          cnt_d = 2'd0;
        end else if (wr) begin
          tail_data_d = wr_data;
          tail_flg_d  = wr_flg;
          cnt_d       = 2'd2;
        end
      end
      default: begin
        if (pop) begin
          head_data_d = tail_data_q;
          head_flg_d  = tail_flg_q;
          if (wr) begin
            tail_data_d = wr_data;
            tail_flg_d  = wr_flg;
          end else begin
            cnt_d = 2'd1;
          end
        end
      end
    endcase

    valid_d = (cnt_d != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_data_q <= '0;
      tail_data_q <= '0;
      head_flg_q  <= '0;
      tail_flg_q  <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      head_data_q <= head_data_d;
      tail_data_q <= tail_data_d;
      head_flg_q  <= head_flg_d;
      tail_flg_q  <= tail_flg_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
    end
  end

  assign head_valid = valid_q;
  assign head_data  = head_data_q;
  assign head_sop   = head_flg_q.sop;
  assign head_eop   = head_flg_q.eop;
  assign count      = cnt_q;
  assign count_next = cnt_d;

endmodule

// File: rtl/fifo_pkt_reader.sv
// Drains header+payload packets from fifo_top onto a valid/ready egress with sop/eop framing.
module fifo_pkt_reader
  import fifo_rd_pkg::*;
#(
  parameter int unsigned W_WIDTH = 32,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_enable,
  output logic               fifo_en,
  output logic               fifo_rd_en,
  input  logic               fifo_empty,
  input  logic [W_WIDTH-1:0] fifo_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W_WIDTH-1:0] out_data,
  output logic               out_sop,
  output logic               out_eop,
  output logic               busy,
  output logic [CNT_W-1:0]   pkt_cnt
);

  rd_state_e            state_q, state_d;
  logic [LEN_W-1:0]     remaining_q, remaining_d;
  logic [LEN_W-1:0]     len_c;
  logic                 rd_pending_q, rd_pending_d;
  logic                 fifo_en_q;
  logic [CNT_W-1:0]     pkt_cnt_q, pkt_cnt_d;
  logic                 busy_q, busy_d;
  logic                 pop_c;
  logic                 cap_sop_c, cap_eop_c;
  logic [BUF_CNT_W-1:0] buf_cnt, buf_cnt_next;

  assign pop_c      = out_valid & out_ready;
  assign fifo_rd_en = rd_enable & ~fifo_empty & has_room(buf_cnt, rd_pending_q, pop_c);
  assign len_c      = fifo_data[LEN_LSB +: LEN_W];

  // Framing advances on capture of the returning FIFO word, not on egress.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    cap_sop_c    = 1'b0;
    cap_eop_c    = 1'b0;
    rd_pending_d = fifo_rd_en;

    if (rd_pending_q) begin
      if (state_q == IDLE) begin
        cap_sop_c = 1'b1;
        if (len_c == '0) begin
          cap_eop_c = 1'b1;
        end else begin
          remaining_d = len_c;
          state_d     = DATA;
        end
      end else begin
        remaining_d = remaining_q - LEN_W'(1);
        if (remaining_q == LEN_W'(1)) begin
          cap_eop_c = 1'b1;
          state_d   = IDLE;
        end
      end
    end

    pkt_cnt_d = pkt_cnt_q + CNT_W'(pop_c & out_eop);
    busy_d    = (state_d == DATA) | (buf_cnt_next != '0) | rd_pending_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      rd_pending_q <= 1'b0;
      fifo_en_q    <= 1'b0;
      pkt_cnt_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      rd_pending_q <= rd_pending_d;
      fifo_en_q    <= rd_enable;
      pkt_cnt_q    <= pkt_cnt_d;
      busy_q       <= busy_d;
    end
  end

  // Reset on the buffer also drops any word whose read was in flight.
  fifo_skid2 #(
    .W (W_WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .wr         (rd_pending_q),
    .wr_data    (fifo_data),
    .wr_sop     (cap_sop_c),
    .wr_eop     (cap_eop_c),
    .pop        (pop_c),
    .head_valid (out_valid),
    .head_data  (out_data),
    .head_sop   (out_sop),
    .head_eop   (out_eop),
    .count      (buf_cnt),
    .count_next (buf_cnt_next)
  );

  assign fifo_en = fifo_en_q;
  assign busy    = busy_q;
  assign pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed bench for fifo_pkt_reader with a packet-level egress scoreboard and FIFO model.
module tb_fifo_pkt_reader;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rd_enable = 1'b0;
  logic             fifo_en;
  logic             fifo_rd_en;
  logic             fifo_empty = 1'b1;
  logic [31:0]      fifo_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_data;
  logic             out_sop;
  logic             out_eop;
  logic             busy;
  logic [CNT_W-1:0] pkt_cnt;

  fifo_pkt_reader #(.W_WIDTH(32), .LEN_W(8), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_enable  (rd_enable),
    .fifo_en    (fifo_en),
    .fifo_rd_en (fifo_rd_en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .busy       (busy),
    .pkt_cnt    (pkt_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // FIFO model: 1-cycle read latency, empty flag updates on the clock.
  logic [31:0] fq[$];
  logic        do_pop = 1'b0;

  always @(negedge clk) do_pop = fifo_rd_en;

  always @(posedge clk) begin
    if (do_pop) begin
      chk("fifo_underflow", 32'(fq.size() != 0), 1);
      if (fq.size() != 0) fifo_data <= fq.pop_front();
    end
    fifo_empty <= (fq.size() == 0);
  end

  // Egress scoreboard built from packet rules.
  typedef struct {
    logic [31:0] d;
    logic        s;
    logic        e;
  } beat_t;

  beat_t            exp_q[$];
  beat_t            b;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic             stall_p = 1'b0;
  logic [31:0]      p_data;
  logic             p_sop, p_eop;

  always @(negedge clk) begin
    if (rst) begin
      stall_p = 1'b0;
    end else begin
      chk("pkt_cnt", 32'(pkt_cnt), 32'(exp_cnt));
      if (stall_p) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_data", out_data, p_data);
        chk("hold_flags", 32'({out_sop, out_eop}), 32'({p_sop, p_eop}));
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 32'(out_valid), 0);
        end else begin
          b = exp_q[0];
          chk("beat_data", out_data, b.d);
          chk("beat_sop", 32'(out_sop), 32'(b.s));
          chk("beat_eop", 32'(out_eop), 32'(b.e));
          if (out_ready) begin
            void'(exp_q.pop_front());
            if (b.e) exp_cnt = exp_cnt + 1'b1;
          end
        end
      end
      stall_p = out_valid & ~out_ready;
      p_data  = out_data;
      p_sop   = out_sop;
      p_eop   = out_eop;
    end
  end

  task automatic exp_add(input logic [31:0] hdr, input logic [31:0] base);
    int len;
    beat_t nb;
    len = int'(hdr[7:0]);
    nb.d = hdr; nb.s = 1'b1; nb.e = (len == 0);
    exp_q.push_back(nb);
    for (int i = 0; i < len; i++) begin
      nb.d = base + 32'(i); nb.s = 1'b0; nb.e = (i == len - 1);
      exp_q.push_back(nb);
    end
  endtask

  task automatic fifo_add(input logic [31:0] hdr, input logic [31:0] base,
                          input int first, input int cnt);
    for (int i = first; i < first + cnt; i++)
      fq.push_back((i == 0) ? hdr : base + 32'(i - 1));
  endtask

  task automatic send_pkt(input logic [31:0] hdr, input logic [31:0] base);
    exp_add(hdr, base);
    fifo_add(hdr, base, 0, int'(hdr[7:0]) + 1);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int max);
    logic done;
    done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && (fq.size() == 0) && !busy && !out_valid;
    end
    chk("drain_done", 32'(done), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int t_rd, t_v, last_v, nbeats, pops;
  logic [31:0] first_data, last_data;
  logic first_sop, last_eop;

  initial begin
    step(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fifo_en", 32'(fifo_en), 0);
    chk("rst_fifo_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_flags", 32'({out_sop, out_eop}), 0);
    @(posedge clk); #1;

    // Header 3 + A,B,C at full rate
    rd_enable = 1'b1; out_ready = 1'b1;
    send_pkt(32'h0000_0003, 32'hA0);
    t_rd = -1; t_v = -1; last_v = -1; nbeats = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (t_rd < 0 && fifo_rd_en) t_rd = i;
      if (out_valid) begin
        if (t_v < 0) begin t_v = i; first_data = out_data; first_sop = out_sop; end
        last_v = i; nbeats++; last_data = out_data; last_eop = out_eop;
      end
    end
    chk("first_latency", 32'(t_v - t_rd), 2);
    chk("beat_count", 32'(nbeats), 4);
    chk("beats_back_to_back", 32'(last_v - t_v), 3);
    chk("hdr_word", first_data, 32'h0000_0003);
    chk("hdr_sop", 32'(first_sop), 1);
    chk("last_word", last_data, 32'hA2);
    chk("last_eop", 32'(last_eop), 1);
    @(posedge clk); #1;
    wait_drain(50);
    chk("pkt_cnt_after_first", 32'(pkt_cnt), 1);

    // Header-only packet
    send_pkt(32'h5A00_0000, 32'h0);
    wait_drain(50);
    chk("pkt_cnt_hdr_only", 32'(pkt_cnt), 2);
    chk("busy_after_hdr_only", 32'(busy), 0);

    // Egress stalled 5 cycles mid-packet
    send_pkt(32'h0000_0005, 32'hC0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid && out_sop && out_ready) break;
    end
    @(posedge clk); #1;
    step(1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) begin
        chk("stall_rd_en_low", 32'(fifo_rd_en), 0);
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_head", out_data, 32'hC1);
        chk("stall_busy", 32'(busy), 1);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain(50);
    chk("pkt_cnt_after_stall", 32'(pkt_cnt), 3);

    // FIFO runs empty mid-packet
    exp_add(32'h0000_0004, 32'hD0);
    fifo_add(32'h0000_0004, 32'hD0, 0, 3);
    step(10);
    @(negedge clk);
    chk("empty_mid_busy", 32'(busy), 1);
    chk("empty_mid_valid", 32'(out_valid), 0);
    chk("empty_mid_rd_en", 32'(fifo_rd_en), 0);
    @(posedge clk); #1;
    fifo_add(32'h0000_0004, 32'hD0, 3, 2);
    wait_drain(50);
    chk("pkt_cnt_after_empty", 32'(pkt_cnt), 4);

    // Reset the cycle after a read is issued
    send_pkt(32'h0000_0002, 32'hE0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_rd_en) break;
    end
    @(posedge clk); #1;
    rst = 1'b1; rd_enable = 1'b0;
    fq.delete(); exp_q.delete(); exp_cnt = '0;
    step(1);
    rst = 1'b0;
    step(1);
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 0);
    chk("post_rst_pkt_cnt", 32'(pkt_cnt), 0);
    chk("post_rst_busy", 32'(busy), 0);
    @(posedge clk); #1;
    rd_enable = 1'b1;
    send_pkt(32'h0000_0102, 32'hF0);
    wait_drain(50);
    chk("pkt_cnt_after_rst", 32'(pkt_cnt), 1);

    // rd_enable dropped mid-payload for 10 cycles
    send_pkt(32'h0000_0006, 32'h60);
    pops = 0;
    for (int i = 0; i < 30 && pops < 3; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) pops++;
    end
    @(posedge clk); #1;
    rd_enable = 1'b0;
    @(negedge clk);
    chk("drop_fifo_en_lag", 32'(fifo_en), 1);
    chk("drop_rd_en", 32'(fifo_rd_en), 0);
    @(negedge clk);
    chk("drop_fifo_en", 32'(fifo_en), 0);
    repeat (8) @(negedge clk);
    chk("drop_busy", 32'(busy), 1);
    chk("drop_drained", 32'(out_valid), 0);
    @(posedge clk); #1;
    rd_enable = 1'b1;
    @(negedge clk);
    chk("raise_fifo_en_lag", 32'(fifo_en), 0);
    @(negedge clk);
    chk("raise_fifo_en", 32'(fifo_en), 1);
    @(posedge clk); #1;
    wait_drain(50);
    chk("pkt_cnt_after_drop", 32'(pkt_cnt), 2);

    // 17 zero-length packets wrap the 4-bit counter
    rd_enable = 1'b0;
    step(1);
    rst = 1'b1; exp_cnt = '0;
    step(2);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) send_pkt(32'(i) << 16, 32'h0);
    rd_enable = 1'b1;
    wait_drain(200);
    chk("pkt_cnt_wrapped", 32'(pkt_cnt), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
